// File: rtl/axi_rr_arb_pkg.sv
// axi_rr_arb_pkg: shared states and AXI encodings for the round-robin master arbiter
package axi_rr_arb_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, ADDR_WR, ADDR_RD, LOCAL_ERR, WAIT_B, WAIT_R, DONE} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'd0;
  function automatic logic [2:0] axsize(input int dw);
    return 3'($clog2(dw / 8));
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first requester at or after ptr, wrapping, as index and one-hot
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;
  // scan from the farthest slot back to ptr so the nearest hit wins
  always_comb begin
    idx = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % N);
      if (req[j]) idx = j;
    end
  end
  assign any = |req;
  assign onehot = any ? {{(N-1){1'b0}}, 1'b1} << idx : '0;
endmodule

// File: rtl/axi_rr_master_arbiter.sv
// axi_rr_master_arbiter: round-robin sharing of one AXI4 master port, one single-beat transfer at a time
module axi_rr_master_arbiter import axi_rr_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'hEC00_0000,
  parameter logic [ADDR_W-1:0] ADDR_SPAN = 32'h0000_1000
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_write,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  input  logic [N_REQ*DATA_W/8-1:0]  req_wstrb,
  output logic [N_REQ-1:0]           req_done,
  output logic [DATA_W-1:0]          req_rdata,
  output logic [1:0]                 req_resp,
  output logic [ADDR_W-1:0]          m_axi_awaddr,
  output logic [7:0]                 m_axi_awlen,
  output logic [2:0]                 m_axi_awsize,
  output logic [1:0]                 m_axi_awburst,
  output logic                       m_axi_awlock,
  output logic [3:0]                 m_axi_awcache,
  output logic [2:0]                 m_axi_awprot,
  output logic [3:0]                 m_axi_awqos,
  output logic [3:0]                 m_axi_awregion,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [DATA_W-1:0]          m_axi_wdata,
  output logic [DATA_W/8-1:0]        m_axi_wstrb,
  output logic                       m_axi_wlast,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  input  logic [1:0]                 m_axi_bresp,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready,
  output logic [ADDR_W-1:0]          m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arlock,
  output logic [3:0]                 m_axi_arcache,
  output logic [2:0]                 m_axi_arprot,
  output logic [3:0]                 m_axi_arqos,
  output logic [3:0]                 m_axi_arregion,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [DATA_W-1:0]          m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);
  localparam int IW = $clog2(N_REQ);
  localparam int SB = DATA_W / 8;
  localparam int AL = $clog2(SB);
  localparam logic [2:0] SIZE = axsize(DATA_W);
  state_t state, nxt;
  logic [IW-1:0] ptr, idx, pidx;
  logic [N_REQ-1:0] gnt, ponehot;
  logic pany, wr, aw_ok, w_ok, aw_hs, w_hs, legal;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdat;
  logic [SB-1:0] strb;
  rr_pick #(.N(N_REQ)) u_pick (.req(req_valid), .ptr(ptr), .onehot(ponehot), .idx(pidx), .any(pany));
  assign legal = addr >= BASE_ADDR && addr - BASE_ADDR < ADDR_SPAN && addr[AL-1:0] == '0;
  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs = m_axi_wvalid & m_axi_wready;
  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = pany ? CHECK : IDLE;
      CHECK:     nxt = !legal ? LOCAL_ERR : wr ? ADDR_WR : ADDR_RD;
      LOCAL_ERR: nxt = DONE;
      ADDR_WR:   nxt = (aw_ok | aw_hs) && (w_ok | w_hs) ? WAIT_B : ADDR_WR;
      WAIT_B:    nxt = m_axi_bvalid ? DONE : WAIT_B;
      ADDR_RD:   nxt = m_axi_arready ? WAIT_R : ADDR_RD;
      WAIT_R:    nxt = m_axi_rvalid ? DONE : WAIT_R;
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      ptr <= '0;
      idx <= '0;
      gnt <= '0;
      wr <= 1'b0;
      addr <= '0;
      wdat <= '0;
      strb <= '0;
      aw_ok <= 1'b0;
      w_ok <= 1'b0;
      req_rdata <= '0;
      req_resp <= RESP_OKAY;
    end else begin
      if (state == IDLE) begin
        idx <= pidx;
        gnt <= ponehot;
        wr <= req_write[pidx];
        addr <= req_addr[pidx*ADDR_W +: ADDR_W];
        wdat <= req_wdata[pidx*DATA_W +: DATA_W];
        strb <= req_wstrb[pidx*SB +: SB];
        aw_ok <= 1'b0;
        w_ok <= 1'b0;
      end
      if (aw_hs) aw_ok <= 1'b1;
      if (w_hs) w_ok <= 1'b1;
      if (state == LOCAL_ERR) begin
        req_rdata <= '0;
        req_resp <= RESP_DECERR;
      end
      if (state == WAIT_B && m_axi_bvalid) begin
        req_rdata <= '0;
        req_resp <= m_axi_bresp;
      end
      if (state == WAIT_R && m_axi_rvalid) begin
        req_rdata <= m_axi_rdata;
        req_resp <= m_axi_rresp;
      end
      if (state == DONE) ptr <= idx == IW'(N_REQ - 1) ? '0 : idx + 1'b1;
    end
  end
  assign req_done = state == DONE ? gnt : '0;
  assign m_axi_awvalid = state == ADDR_WR && !aw_ok;
  assign m_axi_wvalid = state == ADDR_WR && !w_ok;
  assign m_axi_bready = state == WAIT_B;
  assign m_axi_arvalid = state == ADDR_RD;
  assign m_axi_rready = state == WAIT_R;
  assign m_axi_awaddr = addr;
  assign m_axi_araddr = addr;
  assign m_axi_wdata = wdat;
  assign m_axi_wstrb = strb;
  assign m_axi_wlast = 1'b1;
  assign m_axi_awlen = LEN_SINGLE;
  assign m_axi_arlen = LEN_SINGLE;
  assign m_axi_awsize = SIZE;
  assign m_axi_arsize = SIZE;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_awlock = 1'b0;
  assign m_axi_arlock = 1'b0;
  assign m_axi_awcache = '0;
  assign m_axi_arcache = '0;
  assign m_axi_awprot = '0;
  assign m_axi_arprot = '0;
  assign m_axi_awqos = '0;
  assign m_axi_arqos = '0;
  assign m_axi_awregion = '0;
  assign m_axi_arregion = '0;
endmodule
